// File: rtl/id_ctrl_stage_pkg.sv
// rtl/id_ctrl_stage_pkg.sv - opcode/funct constants, ALU op codes and control bundle type
package id_ctrl_stage_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    localparam logic [7:0] EXE_NOP_OP   = 8'h00;
    localparam logic [7:0] EXE_SRL_OP   = 8'h02;
    localparam logic [7:0] EXE_SRA_OP   = 8'h03;
    localparam logic [7:0] EXE_SLLV_OP  = 8'h04;
    localparam logic [7:0] EXE_SRLV_OP  = 8'h06;
    localparam logic [7:0] EXE_SRAV_OP  = 8'h07;
    localparam logic [7:0] EXE_MFHI_OP  = 8'h10;
    localparam logic [7:0] EXE_MTHI_OP  = 8'h11;
    localparam logic [7:0] EXE_MFLO_OP  = 8'h12;
    localparam logic [7:0] EXE_MTLO_OP  = 8'h13;
    localparam logic [7:0] EXE_MULT_OP  = 8'h18;
    localparam logic [7:0] EXE_MULTU_OP = 8'h19;
    localparam logic [7:0] EXE_DIV_OP   = 8'h1A;
    localparam logic [7:0] EXE_DIVU_OP  = 8'h1B;
    localparam logic [7:0] EXE_ADD_OP   = 8'h20;
    localparam logic [7:0] EXE_ADDU_OP  = 8'h21;
    localparam logic [7:0] EXE_SUB_OP   = 8'h22;
    localparam logic [7:0] EXE_SUBU_OP  = 8'h23;
    localparam logic [7:0] EXE_AND_OP   = 8'h24;
    localparam logic [7:0] EXE_OR_OP    = 8'h25;
    localparam logic [7:0] EXE_XOR_OP   = 8'h26;
    localparam logic [7:0] EXE_NOR_OP   = 8'h27;
    localparam logic [7:0] EXE_SLT_OP   = 8'h2A;
    localparam logic [7:0] EXE_SLTU_OP  = 8'h2B;
    localparam logic [7:0] EXE_J_OP     = 8'h4F;
    localparam logic [7:0] EXE_BEQ_OP   = 8'h51;
    localparam logic [7:0] EXE_ADDI_OP  = 8'h55;
    localparam logic [7:0] EXE_ADDIU_OP = 8'h56;
    localparam logic [7:0] EXE_SLTI_OP  = 8'h57;
    localparam logic [7:0] EXE_SLTIU_OP = 8'h58;
    localparam logic [7:0] EXE_ANDI_OP  = 8'h59;
    localparam logic [7:0] EXE_ORI_OP   = 8'h5A;
    localparam logic [7:0] EXE_XORI_OP  = 8'h5B;
    localparam logic [7:0] EXE_LUI_OP   = 8'h5C;
    localparam logic [7:0] EXE_SLL_OP   = 8'h7C;
    localparam logic [7:0] EXE_LW_OP    = 8'hE3;
    localparam logic [7:0] EXE_SW_OP    = 8'hEB;

    typedef struct packed {
        logic regwrite;
        logic regdst;
        logic alusrc;
        logic branch;
        logic memwrite;
        logic memtoreg;
        logic jump;
        logic sign_extd;
        logic write_hilo;
        logic ri;
    } ctrl_t;

    function automatic logic is_hilo_class(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_SPECIAL) &&
               (funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
                              FN_MTHI, FN_MTLO, FN_MFHI, FN_MFLO});
    endfunction

    function automatic logic is_div(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_SPECIAL) && (funct inside {FN_DIV, FN_DIVU});
    endfunction

endpackage

// File: rtl/id_ctrl_stage_hilo_busy_ctr.sv
// rtl/id_ctrl_stage_hilo_busy_ctr.sv - free-running divider occupancy counter
module hilo_busy_ctr #(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy
);
    localparam int CW = $clog2(DIV_CYCLES + 1);

    logic [CW-1:0] count;

    // Keeps counting through pipeline stalls: the divider itself never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(DIV_CYCLES);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/id_ctrl_stage.sv
// rtl/id_ctrl_stage.sv - main decoder with ID/EX control register and HILO interlock
module id_ctrl_stage
    import id_ctrl_stage_pkg::*;
#(
    parameter int ALUOP_W    = 8,
    parameter int DIV_CYCLES = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               stall_i,
    input  logic               flush_i,
    output logic               stall_req,
    output logic               div_busy,
    output logic               ex_valid,
    output logic               ex_ri,
    output logic               ex_regwrite,
    output logic               ex_regdst,
    output logic               ex_alusrc,
    output logic               ex_branch,
    output logic               ex_memwrite,
    output logic               ex_memtoreg,
    output logic               ex_jump,
    output logic               ex_sign_extd,
    output logic               ex_write_hilo,
    output logic [ALUOP_W-1:0] ex_aluop
);
    ctrl_t      ctrl_d;
    logic [7:0] aluop_d;
    logic       r_known;
    logic       r_hilo;

    always_comb begin
        ctrl_d  = '0;
        aluop_d = EXE_NOP_OP;
        r_known = 1'b1;
        r_hilo  = 1'b0;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADD:   aluop_d = EXE_ADD_OP;
                    FN_ADDU:  aluop_d = EXE_ADDU_OP;
                    FN_SUB:   aluop_d = EXE_SUB_OP;
                    FN_SUBU:  aluop_d = EXE_SUBU_OP;
                    FN_AND:   aluop_d = EXE_AND_OP;
                    FN_OR:    aluop_d = EXE_OR_OP;
                    FN_XOR:   aluop_d = EXE_XOR_OP;
                    FN_NOR:   aluop_d = EXE_NOR_OP;
                    FN_SLT:   aluop_d = EXE_SLT_OP;
                    FN_SLTU:  aluop_d = EXE_SLTU_OP;
                    FN_SLL:   aluop_d = EXE_SLL_OP;
                    FN_SRL:   aluop_d = EXE_SRL_OP;
                    FN_SRA:   aluop_d = EXE_SRA_OP;
                    FN_SLLV:  aluop_d = EXE_SLLV_OP;
                    FN_SRLV:  aluop_d = EXE_SRLV_OP;
                    FN_SRAV:  aluop_d = EXE_SRAV_OP;
                    FN_MFHI:  aluop_d = EXE_MFHI_OP;
                    FN_MFLO:  aluop_d = EXE_MFLO_OP;
                    FN_MTHI:  begin aluop_d = EXE_MTHI_OP;  r_hilo = 1'b1; end
                    FN_MTLO:  begin aluop_d = EXE_MTLO_OP;  r_hilo = 1'b1; end
                    FN_MULT:  begin aluop_d = EXE_MULT_OP;  r_hilo = 1'b1; end
                    FN_MULTU: begin aluop_d = EXE_MULTU_OP; r_hilo = 1'b1; end
                    FN_DIV:   begin aluop_d = EXE_DIV_OP;   r_hilo = 1'b1; end
                    FN_DIVU:  begin aluop_d = EXE_DIVU_OP;  r_hilo = 1'b1; end
                    default:  r_known = 1'b0;
                endcase
                if (!r_known) begin
                    ctrl_d.ri = 1'b1;
                end else if (r_hilo) begin
                    ctrl_d.write_hilo = 1'b1;
                end else begin
                    ctrl_d.regwrite = 1'b1;
                    ctrl_d.regdst   = 1'b1;
                end
            end
            OP_LW: begin
                ctrl_d.regwrite  = 1'b1;
                ctrl_d.alusrc    = 1'b1;
                ctrl_d.memtoreg  = 1'b1;
                ctrl_d.sign_extd = 1'b1;
                aluop_d          = EXE_LW_OP;
            end
            OP_SW: begin
                ctrl_d.alusrc    = 1'b1;
                ctrl_d.memwrite  = 1'b1;
                ctrl_d.sign_extd = 1'b1;
                aluop_d          = EXE_SW_OP;
            end
            OP_BEQ: begin
                ctrl_d.branch    = 1'b1;
                ctrl_d.sign_extd = 1'b1;
                aluop_d          = EXE_BEQ_OP;
            end
            OP_J: begin
                ctrl_d.jump      = 1'b1;
                ctrl_d.sign_extd = 1'b1;
                aluop_d          = EXE_J_OP;
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
                case (op)
                    OP_ANDI: aluop_d = EXE_ANDI_OP;
                    OP_ORI:  aluop_d = EXE_ORI_OP;
                    OP_XORI: aluop_d = EXE_XORI_OP;
                    default: aluop_d = EXE_LUI_OP;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                ctrl_d.regwrite  = 1'b1;
                ctrl_d.alusrc    = 1'b1;
                ctrl_d.sign_extd = 1'b1;
                case (op)
                    OP_ADDI:  aluop_d = EXE_ADDI_OP;
                    OP_ADDIU: aluop_d = EXE_ADDIU_OP;
                    OP_SLTI:  aluop_d = EXE_SLTI_OP;
                    default:  aluop_d = EXE_SLTIU_OP;
                endcase
            end
            default: ctrl_d.ri = 1'b1;
        endcase
    end

    logic  load_ex;
    logic  div_load;
    ctrl_t ex_ctrl;

    assign stall_req = id_valid & div_busy & is_hilo_class(op, funct);
    assign load_ex   = id_valid & ~flush_i & ~stall_req;
    // A flushed or interlocked DIV never reaches EX, so it never starts the count.
    assign div_load  = ~stall_i & load_ex & is_div(op, funct);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_aluop <= '0;
        end else if (stall_i) begin
            ex_valid <= ex_valid;
        end else if (load_ex) begin
            ex_valid <= 1'b1;
            ex_ctrl  <= ctrl_d;
            ex_aluop <= ALUOP_W'(aluop_d);
        end else begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_aluop <= '0;
        end
    end

    hilo_busy_ctr #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_hilo_busy_ctr (
        .clk  (clk),
        .rst  (rst),
        .load (div_load),
        .busy (div_busy)
    );

    assign ex_regwrite   = ex_ctrl.regwrite;
    assign ex_regdst     = ex_ctrl.regdst;
    assign ex_alusrc     = ex_ctrl.alusrc;
    assign ex_branch     = ex_ctrl.branch;
    assign ex_memwrite   = ex_ctrl.memwrite;
    assign ex_memtoreg   = ex_ctrl.memtoreg;
    assign ex_jump       = ex_ctrl.jump;
    assign ex_sign_extd  = ex_ctrl.sign_extd;
    assign ex_write_hilo = ex_ctrl.write_hilo;
    assign ex_ri         = ex_ctrl.ri;

endmodule
